// File: rtl/dkong_vram_arb_pkg.sv
// dkong_vram_arb_pkg: shared types and constants for the tile VRAM arbiter
package dkong_vram_arb_pkg;
  localparam int HS_AGE_W = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_CAP} state_t;
  typedef enum logic {OWN_CPU, OWN_HS} owner_t;
endpackage

// File: rtl/dkong_vram_arb.sv
// dkong_vram_arb: shares the tile VRAM CPU port between the Z80 and hiscore engine
module dkong_vram_arb
  import dkong_vram_arb_pkg::*;
#(
  parameter int HS_AGE_MAX = 3
) (
  input  logic       CLK_24M,
  input  logic       I_RST,
  input  logic       CLK_EN,
  input  logic       I_CMPBLK,
  input  logic       I_CPU_REQ,
  input  logic       I_CPU_WE,
  input  logic [9:0] I_CPU_AB,
  input  logic [7:0] I_CPU_DB,
  output logic [7:0] O_CPU_DB,
  output logic       O_CPU_ACK,
  output logic       O_WAITn,
  input  logic       hs_req,
  input  logic       hs_we,
  input  logic [9:0] hs_address,
  input  logic [7:0] hs_data_in,
  output logic [7:0] hs_data_out,
  output logic       hs_ack,
  output logic [9:0] O_RAM_AB,
  output logic [7:0] O_RAM_DI,
  output logic       O_RAM_CE,
  output logic       O_RAM_WE,
  input  logic [7:0] I_RAM_DO,
  output logic       O_COLLIDE
);
  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic [HS_AGE_W-1:0] age_q, age_d;
  logic cmpblk_q;
  logic [9:0] ab_q, ab_d;
  logic [7:0] di_q, di_d, cpu_db_q, cpu_db_d, hs_db_q, hs_db_d;
  logic ce_q, ce_d, we_q, we_d, cpu_ack_q, cpu_ack_d, hs_ack_q, hs_ack_d, collide_q, collide_d;
  logic grant, hs_win;
  // CAP may grant directly so back-to-back accesses sustain one per two ticks
  assign grant  = (state_q != ST_ACC) & ~I_CMPBLK & (I_CPU_REQ | hs_req);
  assign hs_win = hs_req & (~I_CPU_REQ | (age_q == HS_AGE_W'(HS_AGE_MAX)));
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    age_d     = age_q;
    ab_d      = ab_q;
    di_d      = di_q;
    ce_d      = ce_q;
    we_d      = we_q;
    cpu_ack_d = 1'b0;
    hs_ack_d  = 1'b0;
    cpu_db_d  = cpu_db_q;
    hs_db_d   = hs_db_q;
    collide_d = (state_q != ST_IDLE) & I_CMPBLK & ~cmpblk_q;
    if (state_q == ST_ACC) begin
      state_d   = ST_CAP;
      cpu_ack_d = (owner_q == OWN_CPU) & I_CPU_REQ;
      hs_ack_d  = (owner_q == OWN_HS) & hs_req;
      cpu_db_d  = (cpu_ack_d & ~we_q) ? I_RAM_DO : cpu_db_q;
      hs_db_d   = (hs_ack_d & ~we_q) ? I_RAM_DO : hs_db_q;
    end else if (grant) begin
      state_d = ST_ACC;
      owner_d = hs_win ? OWN_HS : OWN_CPU;
      age_d   = hs_win ? '0 : (hs_req ? age_q + 1'b1 : age_q);
      ab_d    = hs_win ? hs_address : I_CPU_AB;
      we_d    = hs_win ? hs_we : I_CPU_WE;
      ce_d    = 1'b1;
      di_d    = we_d ? (hs_win ? hs_data_in : I_CPU_DB) : 8'h00;
    end else begin
      state_d = ST_IDLE;
      ce_d    = 1'b0;
      we_d    = 1'b0;
    end
  end
  always_ff @(posedge CLK_24M or posedge I_RST) begin
    if (I_RST) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_CPU;
      age_q     <= '0;
      cmpblk_q  <= 1'b0;
      ab_q      <= '0;
      di_q      <= '0;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      cpu_ack_q <= 1'b0;
      hs_ack_q  <= 1'b0;
      cpu_db_q  <= '0;
      hs_db_q   <= '0;
      collide_q <= 1'b0;
    end else if (CLK_EN) begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      age_q     <= age_d;
      cmpblk_q  <= I_CMPBLK;
      ab_q      <= ab_d;
      di_q      <= di_d;
      ce_q      <= ce_d;
      we_q      <= we_d;
      cpu_ack_q <= cpu_ack_d;
      hs_ack_q  <= hs_ack_d;
      cpu_db_q  <= cpu_db_d;
      hs_db_q   <= hs_db_d;
      collide_q <= collide_d;
    end
  end
  assign O_RAM_AB    = ab_q;
  assign O_RAM_DI    = di_q;
  assign O_RAM_CE    = ce_q;
  assign O_RAM_WE    = we_q;
  assign O_CPU_ACK   = cpu_ack_q;
  assign hs_ack      = hs_ack_q;
  assign O_CPU_DB    = cpu_db_q;
  assign hs_data_out = hs_db_q;
  assign O_COLLIDE   = collide_q;
  assign O_WAITn     = ~(I_CPU_REQ & ~cpu_ack_q);
endmodule

// File: tb/tb_dkong_vram_arb.sv
// tb_dkong_vram_arb: directed scoreboard bench for the tile VRAM arbiter
module tb_dkong_vram_arb;
  logic clk = 0, rst = 1, en = 0, cmpblk = 0;
  logic cpu_req = 0, cpu_we = 0, hs_req = 0, hs_we = 0;
  logic [9:0] cpu_ab = 0, hs_ab = 0, ram_ab;
  logic [7:0] cpu_di = 0, hs_di = 0, cpu_do, hs_do, ram_di, ram_do;
  logic cpu_ack, waitn, hs_ack, ram_ce, ram_we, collide;
  logic [7:0] mem [1024];
  int tick_cnt = 0, total_cnt = 0, pass_cnt = 0;
  typedef struct {bit hs; bit rd; logic [7:0] data; int at;} exp_t;
  exp_t sb[$];

  dkong_vram_arb dut (
    .CLK_24M(clk), .I_RST(rst), .CLK_EN(en), .I_CMPBLK(cmpblk),
    .I_CPU_REQ(cpu_req), .I_CPU_WE(cpu_we), .I_CPU_AB(cpu_ab), .I_CPU_DB(cpu_di),
    .O_CPU_DB(cpu_do), .O_CPU_ACK(cpu_ack), .O_WAITn(waitn),
    .hs_req(hs_req), .hs_we(hs_we), .hs_address(hs_ab), .hs_data_in(hs_di),
    .hs_data_out(hs_do), .hs_ack(hs_ack),
    .O_RAM_AB(ram_ab), .O_RAM_DI(ram_di), .O_RAM_CE(ram_ce), .O_RAM_WE(ram_we),
    .I_RAM_DO(ram_do), .O_COLLIDE(collide)
  );

  initial forever #5 clk = ~clk;
  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      c++;
      en = (c % 4 == 0);
    end
  end
  always @(posedge clk) begin
    if (ram_ce & ram_we) mem[ram_ab] <= ram_di;
    if (ram_ce) ram_do <= mem[ram_ab];
  end

  task automatic check(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", nm, act, exp, tick_cnt);
  endtask

  task automatic push(input bit hs, input bit rd, input logic [7:0] d, input int at);
    exp_t e;
    e.hs = hs; e.rd = rd; e.data = d; e.at = at;
    sb.push_back(e);
  endtask

  task automatic score(input bit hs, input logic [7:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      check(hs ? "hs_ack_spurious" : "cpu_ack_spurious", 1, 0);
    end else begin
      e = sb.pop_front();
      check("ack_owner", hs, e.hs);
      if (e.rd) check(hs ? "hs_rdata" : "cpu_rdata", d, e.data);
      check("ack_tick", tick_cnt, e.at);
    end
  endtask

  initial begin
    bit cp = 0, hp = 0;
    forever begin
      @(posedge clk);
      if (en) begin
        #1;
        tick_cnt++;
        if (cpu_ack && !cp) score(0, cpu_do);
        if (hs_ack && !hp) score(1, hs_do);
        cp = cpu_ack;
        hp = hs_ack;
      end
    end
  end

  task automatic tick();
    do @(posedge clk); while (!en);
    #2;
  endtask

  task automatic wait_ack(input bit hs);
    for (int i = 0; i < 20; i++) begin
      if (hs ? hs_ack : cpu_ack) break;
      tick();
    end
    check(hs ? "hs_ack_timeout" : "cpu_ack_timeout", hs ? hs_ack : cpu_ack, 1);
  endtask

  initial begin
    int k;
    repeat (6) @(posedge clk);
    #2;
    check("rst_ce", ram_ce, 0);
    check("rst_we", ram_we, 0);
    check("rst_ab", ram_ab, 0);
    check("rst_di", ram_di, 0);
    check("rst_acks", {cpu_ack, hs_ack, collide}, 0);
    check("rst_data", {cpu_do, hs_do}, 0);
    check("rst_waitn_idle", waitn, 1);
    cpu_req = 1;
    #1 check("rst_waitn_req", waitn, 0);
    cpu_req = 0;
    tick();
    rst = 0;
    tick();
    // CPU write 0x3A5 <- 0x5C
    cpu_we = 1; cpu_ab = 10'h3A5; cpu_di = 8'h5C; cpu_req = 1;
    push(0, 0, 8'h00, tick_cnt + 2);
    tick();
    check("wr_grant_we", {ram_ce, ram_we}, 2'b11);
    check("wr_grant_ab", ram_ab, 10'h3A5);
    check("wr_grant_di", ram_di, 8'h5C);
    check("wr_waitn_low", waitn, 0);
    tick();
    check("wr_ack_we", ram_we, 1);
    check("wr_waitn_rel", waitn, 1);
    cpu_req = 0; cpu_we = 0;
    tick();
    check("wr_cap_ce", {ram_ce, ram_we}, 0);
    check("wr_mem", mem[10'h3A5], 8'h5C);
    // CPU read held off by display fetch
    cmpblk = 1; cpu_ab = 10'h3A5; cpu_req = 1;
    repeat (3) tick();
    check("blk_no_grant", ram_ce, 0);
    check("blk_waitn", waitn, 0);
    cmpblk = 0;
    push(0, 1, 8'h5C, tick_cnt + 2);
    tick();
    check("blk_rel_grant", {ram_ce, ram_we}, 2'b10);
    check("rd_di_zero", ram_di, 0);
    wait_ack(0);
    cpu_req = 0;
    tick();
    // fairness with both requesters held
    cpu_we = 1; cpu_ab = 10'h010; cpu_di = 8'hA1;
    hs_we = 1; hs_ab = 10'h020; hs_di = 8'hB2;
    k = tick_cnt;
    for (int i = 0; i < 8; i++) push(i % 4 == 3, 0, 8'h00, k + 2 + 2 * i);
    cpu_req = 1; hs_req = 1;
    repeat (16) tick();
    cpu_req = 0; hs_req = 0; cpu_we = 0; hs_we = 0;
    repeat (2) tick();
    check("fair_drain", sb.size(), 0);
    check("fair_mem", {mem[10'h010], mem[10'h020]}, 16'hA1B2);
    // simultaneous rise, age cleared by last HS grant
    k = tick_cnt;
    push(0, 1, 8'hA1, k + 2);
    push(1, 1, 8'hB2, k + 4);
    cpu_req = 1; hs_req = 1;
    wait_ack(0);
    cpu_req = 0;
    wait_ack(1);
    hs_req = 0;
    tick();
    check("sim_cpu_db", cpu_do, 8'hA1);
    check("sim_hs_db", hs_do, 8'hB2);
    // collision on hiscore write
    hs_we = 1; hs_ab = 10'h055; hs_di = 8'h11; hs_req = 1;
    push(1, 0, 8'h00, tick_cnt + 2);
    tick();
    cmpblk = 1;
    tick();
    check("col_pulse", collide, 1);
    hs_req = 0; hs_we = 0;
    tick();
    check("col_pulse_end", collide, 0);
    check("col_mem", mem[10'h055], 8'h11);
    cmpblk = 0;
    tick();
    // requester withdraws during ACC: no ack, data untouched
    cpu_ab = 10'h055; cpu_req = 1;
    tick();
    cpu_req = 0;
    tick();
    check("drop_no_ack", cpu_ack, 0);
    tick();
    check("drop_db_kept", cpu_do, 8'hA1);
    // reset mid-access
    cpu_ab = 10'h3A5; cpu_req = 1;
    tick();
    check("rst_mid_grant", ram_ce, 1);
    rst = 1;
    #1;
    check("rst_mid_ce", {ram_ce, ram_we}, 0);
    check("rst_mid_db", cpu_do, 0);
    tick();
    check("rst_mid_ack", cpu_ack, 0);
    tick();
    rst = 0;
    push(0, 1, 8'h5C, tick_cnt + 2);
    tick();
    check("rst_regrant", {ram_ce, ram_ab}, {1'b1, 10'h3A5});
    wait_ack(0);
    cpu_req = 0;
    repeat (2) tick();
    check("final_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
